xbus_arbiter: RTL and testbench
===============================

# xbus_arbiter

Central XBUS arbiter and bus-phase sequencer. Shares the XBUS among up to 16 masters with fair round-robin arbitration, drives the one-hot `sig_grant` and the `sig_start` arbitration strobe, and tracks each transfer through address and data phases. It lives in the XBUS environment alongside `xbus_if`, drives those signals onto the bus, and adds a wait-state watchdog.

## Interface
- `NUM_MASTERS`, default 16: active requesters, 1..16; request bits at or above this index are ignored, and the matching grant bits stay 0.
- `MAX_WAIT`, default 15: number of consecutive data-phase cycles with `sig_wait` high that triggers an abort; 0 disables the watchdog.
- `sig_clock`  in  1: single clock; all logic on posedge.
- `sig_reset_n`  in  1: asynchronous, active-low reset.
- `sig_request`  in  16: per-master bus request, level.
- `sig_read`  in  1: read indication, sampled in the address phase.
- `sig_write`  in  1: write indication, sampled in the address phase.
- `sig_bip`  in  1: burst in progress, from the master.
- `sig_wait`  in  1: slave wait.
- `sig_error`  in  1: slave error.
- `sig_grant`  out  16: one-hot or zero grant; high only in the address phase.
- `sig_start`  out  1: high during arbitration cycles.
- `sig_timeout`  out  1: one-cycle pulse when a transfer is aborted by the watchdog.

## Operation
- FSM states, in a shared enum: IDLE, ARB, ADDR, DATA.
  - IDLE: entered only from reset. Always moves to ARB on the next posedge.
  - ARB: `sig_start`=1. At the posedge ending the cycle, `sig_request` is sampled.
    - Any valid request: go to ADDR and register the winner in `sig_grant`.
    - No valid request: stay in ARB, so `sig_start` stays 1.
  - ADDR: `sig_grant`=winner and `sig_start`=0.
    - `sig_read|sig_write` sampled 1: go to DATA.
    - Otherwise it is a NOP: go back to ARB.
  - DATA: `sig_grant`=0 and `sig_start`=0.
    - `!sig_bip && !sig_wait`: go to ARB (normal end).
    - `sig_error && !sig_wait`: go to ARB even if `sig_bip` is set (burst aborted).
    - Wait counter reaches `MAX_WAIT`: pulse `sig_timeout` and go to ARB.
- Round-robin:
  - Pointer `ptr` (4 bit) resets to 0.
  - The winner is the first requester found scanning `ptr`, `ptr`+1, … with wrap-around modulo `NUM_MASTERS`.
  - Whenever a grant is issued to master i, `ptr` becomes (i+1) mod `NUM_MASTERS`, including for NOP transfers.
- Wait counter:
  - Cleared on DATA entry and whenever `sig_wait`=0.
  - Increments each DATA cycle with `sig_wait`=1 and saturates at `MAX_WAIT`.
  - Abort occurs on the posedge at which counter==`MAX_WAIT`-1 and `sig_wait`=1, i.e. after `MAX_WAIT` consecutive wait cycles.
- All outputs are registered: computed from next-state and driven from flops. No combinational path from any input to any output.

## Timing
- Reset values while `sig_reset_n`=0: state=IDLE, `sig_grant`=0, `sig_start`=0, `sig_timeout`=0, `ptr`=0, wait counter=0.
- After reset release: IDLE for one cycle, then `sig_start`=1 from the second posedge onward.
- Grant latency: a request sampled at the posedge ending an ARB cycle produces `sig_grant` in the very next cycle.
- `sig_grant` is high for exactly one cycle per transfer and is never multi-hot.
- Minimum transfer is 3 cycles: ARB, ADDR, one DATA cycle with no wait and no bip.
- A NOP transfer is 2 cycles: ARB, ADDR.
- A request that drops during ADDR or DATA has no effect on the current transfer.
- Requesters hold their request until granted; the arbiter does not latch requests.
- `sig_timeout` and a normal end never coincide: if `sig_wait`=0 at the abort posedge, the transfer ends normally.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronously), without waiting for a clock edge.

## Structure
- Package `xbus_pkg` holds:
  - `xbus_arb_state_t` enum (IDLE, ARB, ADDR, DATA);
  - `XBUS_MAX_MASTERS`=16.
- One sub-module, `xbus_rr_picker`: combinational. Inputs are the masked request vector and `ptr`; outputs are the one-hot winner and its index.

## Test plan
- Reset, then request=16'h0001 held:
  - `sig_start`=1 on cycle 2;
  - `sig_grant`=16'h0001 on cycle 3;
  - with write=1 and bip=0/wait=0, back to ARB on cycle 5.
- request=16'hFFFF held, with single-beat writes throughout: grants cycle 0001, 0002, … 8000, then 0001 again (wrap-around), one per transfer.
- `NUM_MASTERS`=4, request=16'h0010 only: `sig_grant` never asserts and `sig_start` stays 1.
- Grant with read=0 and write=0 (NOP): next cycle is ARB, and `ptr` has advanced.
- `MAX_WAIT`=3, `sig_wait` held 1 in DATA: `sig_timeout` pulses once after the 3rd wait cycle and the FSM returns to ARB. Also check error=1/wait=0 with bip=1: the burst ends and the FSM returns to ARB.
- `sig_reset_n` pulsed low during DATA: `sig_grant`=0, `sig_start`=0 and `sig_timeout`=0 immediately; after release, `ptr`=0, so master 0 wins if requesting.

Source files
------------

// File: rtl/xbus_pkg.sv
// Shared types and sizing for the XBUS arbiter slice.
package xbus_pkg;

    localparam int unsigned XBUS_MAX_MASTERS = 16;
    localparam int unsigned XBUS_IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        ADDR,
        DATA
    } xbus_arb_state_t;

endpackage

// File: rtl/xbus_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module xbus_rr_picker
    import xbus_pkg::*;
(
    input  logic [XBUS_MAX_MASTERS-1:0] req,
    input  logic [XBUS_IDX_W-1:0]       ptr,
    output logic [XBUS_MAX_MASTERS-1:0] winner_c,
    output logic [XBUS_IDX_W-1:0]       win_idx_c,
    output logic                        valid_c
);

    logic [XBUS_IDX_W-1:0] cand;

    // Masked-off requesters are zero, so a full 16-way wrap equals a wrap modulo NUM_MASTERS.
    always_comb begin
        winner_c  = '0;
        win_idx_c = '0;
        valid_c   = 1'b0;
        cand      = '0;
        for (int i = 0; i < XBUS_MAX_MASTERS; i++) begin
            cand = ptr + XBUS_IDX_W'(i);
            if (!valid_c && req[cand]) begin
                valid_c   = 1'b1;
                win_idx_c = cand;
            end
        end
        if (valid_c) begin
            winner_c[win_idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// XBUS arbiter and bus-phase sequencer: round-robin grant, ARB/ADDR/DATA tracking, wait watchdog.
module xbus_arbiter
    import xbus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 16,
    parameter int unsigned MAX_WAIT    = 15
) (
    input  logic                        sig_clock,
    input  logic                        sig_reset_n,
    input  logic [XBUS_MAX_MASTERS-1:0] sig_request,
    input  logic                        sig_read,
    input  logic                        sig_write,
    input  logic                        sig_bip,
    input  logic                        sig_wait,
    input  logic                        sig_error,
    output logic [XBUS_MAX_MASTERS-1:0] sig_grant,
    output logic                        sig_start,
    output logic                        sig_timeout
);

    localparam int unsigned WCNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [XBUS_MAX_MASTERS-1:0] REQ_MASK =
        (NUM_MASTERS >= XBUS_MAX_MASTERS) ? '1
                                          : XBUS_MAX_MASTERS'((32'd1 << NUM_MASTERS) - 32'd1);
    localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(MAX_WAIT);
    localparam logic [WCNT_W-1:0] WAIT_LAST = (MAX_WAIT == 0) ? '0 : WCNT_W'(MAX_WAIT - 1);
    localparam logic [XBUS_IDX_W:0] NUM_M   = (XBUS_IDX_W + 1)'(NUM_MASTERS);

    xbus_arb_state_t               state, state_nxt;
    logic [XBUS_IDX_W-1:0]         ptr, ptr_nxt;
    logic [WCNT_W-1:0]             wcnt, wcnt_nxt;
    logic [XBUS_MAX_MASTERS-1:0]   grant_nxt;
    logic                          start_nxt;
    logic                          timeout_nxt;
    logic [XBUS_IDX_W:0]           idx_inc;

    logic [XBUS_MAX_MASTERS-1:0]   win_onehot;
    logic [XBUS_IDX_W-1:0]         win_idx;
    logic                          win_valid;

    xbus_rr_picker u_picker (
        .req       (sig_request & REQ_MASK),
        .ptr       (ptr),
        .winner_c  (win_onehot),
        .win_idx_c (win_idx),
        .valid_c   (win_valid)
    );

    // Next-state, pointer, wait counter and next output values.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        wcnt_nxt    = wcnt;
        grant_nxt   = '0;
        timeout_nxt = 1'b0;
        idx_inc     = {1'b0, win_idx} + (XBUS_IDX_W + 1)'(1);
        case (state)
            IDLE: state_nxt = ARB;
            ARB: begin
                if (win_valid) begin
                    state_nxt = ADDR;
                    grant_nxt = win_onehot;
                    ptr_nxt   = (idx_inc >= NUM_M) ? '0 : idx_inc[XBUS_IDX_W-1:0];
                end
            end
            ADDR: begin
                if (sig_read || sig_write) begin
                    state_nxt = DATA;
                    wcnt_nxt  = '0;
                end else begin
                    state_nxt = ARB;
                end
            end
            DATA: begin
                if (!sig_wait) begin
                    wcnt_nxt = '0;
                    if (!sig_bip || sig_error) begin
                        state_nxt = ARB;
                    end
                end else begin
                    if (wcnt != WAIT_MAX) begin
                        wcnt_nxt = wcnt + WCNT_W'(1);
                    end
                    if ((MAX_WAIT != 0) && (wcnt == WAIT_LAST)) begin
                        state_nxt   = ARB;
                        timeout_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        start_nxt = (state_nxt == ARB);
    end

    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            wcnt        <= '0;
            sig_grant   <= '0;
            sig_start   <= 1'b0;
            sig_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            wcnt        <= wcnt_nxt;
            sig_grant   <= grant_nxt;
            sig_start   <= start_nxt;
            sig_timeout <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed self-checking bench for xbus_arbiter (16 masters / MAX_WAIT=3, plus a 4-master instance).
module tb_xbus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic        rd = 1'b0, wr = 1'b0, bip = 1'b0, wt = 1'b0, err = 1'b0;
    logic [15:0] grant, grant4;
    logic        start, start4, tmo, tmo4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xbus_arbiter #(.NUM_MASTERS(16), .MAX_WAIT(3)) dut (
        .sig_clock(clk), .sig_reset_n(rst_n), .sig_request(req),
        .sig_read(rd), .sig_write(wr), .sig_bip(bip), .sig_wait(wt), .sig_error(err),
        .sig_grant(grant), .sig_start(start), .sig_timeout(tmo)
    );

    xbus_arbiter #(.NUM_MASTERS(4)) dut4 (
        .sig_clock(clk), .sig_reset_n(rst_n), .sig_request(req),
        .sig_read(rd), .sig_write(wr), .sig_bip(bip), .sig_wait(wt), .sig_error(err),
        .sig_grant(grant4), .sig_start(start4), .sig_timeout(tmo4)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns in the first ARB cycle (cycle 2 after release).
    task automatic do_reset;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_start", 32'(start), 32'h0);
        check_eq("rst_timeout", 32'(tmo), 32'h0);
        rst_n = 1'b1;
        #1;
        check_eq("idle_start", 32'(start), 32'h0);
        tick();
        check_eq("arb_start", 32'(start), 32'h1);
        check_eq("arb_grant", 32'(grant), 32'h0);
    endtask

    task automatic async_reset_check(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_grant"}, 32'(grant), 32'h0);
        check_eq({tag, "_start"}, 32'(start), 32'h0);
        check_eq({tag, "_timeout"}, 32'(tmo), 32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] exp_g;

        // Basic single-master write
        req = 16'h0001; wr = 1'b1;
        do_reset();
        tick(); check_eq("t1_grant", 32'(grant), 32'h0001);
        check_eq("t1_addr_start", 32'(start), 32'h0);
        tick(); check_eq("t1_data_grant", 32'(grant), 32'h0);
        check_eq("t1_data_start", 32'(start), 32'h0);
        req = '0;
        tick(); check_eq("t1_end_start", 32'(start), 32'h1);
        tick(); check_eq("t1_idle_arb", 32'(start), 32'h1);
        check_eq("t1_no_grant", 32'(grant), 32'h0);

        // Round-robin over all 16 masters with wrap-around
        req = 16'hFFFF; wr = 1'b1;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            exp_g = 16'h0001 << (k % 16);
            tick(); check_eq("rr_grant", 32'(grant), 32'(exp_g));
            tick();
            tick(); check_eq("rr_start", 32'(start), 32'h1);
        end

        // NOP transfer advances the pointer
        req = 16'h0004; wr = 1'b0; rd = 1'b0;
        do_reset();
        tick(); check_eq("nop_grant", 32'(grant), 32'h0004);
        tick(); check_eq("nop_arb", 32'(start), 32'h1);
        check_eq("nop_arb_grant", 32'(grant), 32'h0);
        req = 16'h0014;
        tick(); check_eq("nop_ptr_adv", 32'(grant), 32'h0010);
        req = '0;
        tick();

        // Request above NUM_MASTERS ignored by the 4-master instance
        req = 16'h0010;
        do_reset();
        tick(); check_eq("m16_grant4", 32'(grant), 32'h0010);
        for (int k = 0; k < 4; k++) begin
            check_eq("nm4_grant", 32'(grant4), 32'h0);
            check_eq("nm4_start", 32'(start4), 32'h1);
            tick();
        end
        req = '0;

        // Watchdog abort after 3 wait cycles
        req = 16'h0001; wr = 1'b1; bip = 1'b0; wt = 1'b1;
        do_reset();
        tick(); check_eq("wd_grant", 32'(grant), 32'h0001);
        req = '0;
        tick(); check_eq("wd_d1_tmo", 32'(tmo), 32'h0);
        tick(); check_eq("wd_d2_tmo", 32'(tmo), 32'h0);
        tick(); check_eq("wd_d3_tmo", 32'(tmo), 32'h0);
        check_eq("wd_d3_start", 32'(start), 32'h0);
        tick(); check_eq("wd_pulse", 32'(tmo), 32'h1);
        check_eq("wd_arb", 32'(start), 32'h1);
        tick(); check_eq("wd_pulse_end", 32'(tmo), 32'h0);

        // Error with wait low aborts a burst
        wt = 1'b0; bip = 1'b1; req = 16'h0001;
        tick(); check_eq("err_grant", 32'(grant), 32'h0001);
        req = '0;
        tick();
        tick(); check_eq("err_burst_hold", 32'(start), 32'h0);
        err = 1'b1;
        tick(); check_eq("err_arb", 32'(start), 32'h1);
        check_eq("err_tmo", 32'(tmo), 32'h0);
        err = 1'b0; bip = 1'b0;

        // Asynchronous reset during ADDR and during DATA
        req = 16'h0001; bip = 1'b1;
        tick(); check_eq("ar_addr_grant", 32'(grant), 32'h0001);
        async_reset_check("ar_addr");
        tick(); check_eq("ar_rel_start", 32'(start), 32'h1);
        tick(); check_eq("ar_grant2", 32'(grant), 32'h0001);
        tick();
        req = 16'h0003;
        async_reset_check("ar_data");
        tick(); check_eq("ar_data_rel_start", 32'(start), 32'h1);
        tick(); check_eq("ar_ptr_zero", 32'(grant), 32'h0001);
        req = '0; bip = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
